mem_led_scanner: RTL and testbench
==================================

// Module: mem_led_scanner
// PURPOSE
//   Downstream consumer of the data memory's 128-bit LED snapshot bus (16 x 8-bit bytes).
//   Scans the bytes onto the 8 board LEDs one at a time:
//   - auto mode: fixed dwell time per byte;
//   - manual mode: one step per debounced pushbutton press.
//   Latches a coherent copy of the memory at each sweep start, so one sweep never mixes old and new data.
// PARAMETERS
//   DWELL_CYCLES     50_000_000  clk cycles each byte is shown in auto mode (>=1)
//   DEBOUNCE_CYCLES  1_000_000   cycles the synced button must be stable before its level is accepted (>=1)
// PORTS
//   clk         in   1    system clock; all state on posedge clk
//   rst_n       in   1    asynchronous, active-low reset
//   mem_bytes   in   128  memory snapshot; byte i = mem_bytes[8*i+7 : 8*i]
//   mode_auto   in   1    1 = auto scan, 0 = manual step
//   btn_next    in   1    raw, asynchronous, bouncy pushbutton; active high
//   hold        in   1    1 = freeze index, dwell counter and snapshot
//   led         out  8    byte currently displayed
//   led_index   out  4    index of the displayed byte
//   adv_pulse   out  1    1-cycle strobe in the cycle led_index changes
// BEHAVIOUR
//   Reset (rst_n low, asynchronous):
//   - state=S_LOAD, index=0, dwell=0, snap=0, led=0, led_index=0, adv_pulse=0;
//   - sync/debounce registers=0.
//   FSM states S_LOAD, S_AUTO, S_MANUAL:
//   - S_LOAD (exactly 1 cycle after reset release): snap<=mem_bytes;
//     next state = S_AUTO if mode_auto else S_MANUAL.
//   - S_AUTO: dwell+=1 each cycle. When dwell==DWELL_CYCLES-1: dwell<=0, index<=index+1.
//     mode_auto=0 -> S_MANUAL with dwell<=0, index unchanged.
//   - S_MANUAL: each debounced rising edge of btn_next -> index<=index+1.
//     mode_auto=1 -> S_AUTO with dwell starting at 0.
//   Index and snapshot:
//   - index is 4 bits and wraps 15 -> 0.
//   - On a wrap step, snap<=mem_bytes in the same cycle, so the new sweep shows fresh data.
//   - snap is never updated at any other time except S_LOAD.
//   hold=1:
//   - index, dwell and snap do not change; no adv_pulse; mode_auto changes are deferred.
//   - Button edges seen during hold are discarded.
//   - On release, dwell resumes from its held value.
//   - hold overrides every advance and every transition except reset.
//   Button path:
//   - 2-FF synchronizer.
//   - Debounced level changes only after the synced value differs from it for DEBOUNCE_CYCLES consecutive cycles.
//   - A rising edge of the debounced level gives one step request.
//   - Requests in S_AUTO or S_LOAD are dropped, never queued.
//   Outputs (all registered):
//   - led_index <= index; led <= snap byte[index].
//   - led and led_index always refer to the same index and snapshot: 1-cycle latency from index/snap.
//   - adv_pulse <= (index advanced this cycle); it aligns with the led_index update.
//   - First valid led: 2 cycles after reset release.
//   - Total press latency: button rise to led update = 2 sync + DEBOUNCE_CYCLES + 2 cycles.
//   - DWELL_CYCLES=1: index advances every S_AUTO cycle.
// TESTING (bench uses DWELL_CYCLES=4, DEBOUNCE_CYCLES=3)
//   1. Auto sweep. Reset; byte i = i+1; mode_auto=1.
//      -> led_index 0,1,..,15,0 changing every 4 cycles; led = led_index+1;
//      -> one adv_pulse per change; led=0x01 two cycles after release.
//   2. Coherent snapshot. At led_index=5, set all bytes to 0xAA.
//      -> indices 5..15 still show old values (6..16);
//      -> after wrap, index 0 shows 0xAA.
//   3. Manual debounce. mode_auto=0; btn glitches of 1-2 cycles -> no step.
//      Clean press held 10 cycles -> exactly one step (0 -> 1).
//      Release 10 cycles, press again -> 2.
//   4. Hold. hold=1 for 20 cycles at index 7, dwell=2, with a button press and mode_auto toggles.
//      -> led_index stays 7, no adv_pulse;
//      -> after release, the step comes 2 cycles later (dwell resumes at 2).
//   5. Async reset mid-sweep at index 9. Assert rst_n=0 off-edge.
//      -> led=0, led_index=0, adv_pulse=0 immediately;
//      -> after release, S_LOAD recaptures mem_bytes.
//   6. Auto mode at index 15, press btn -> ignored.
//      Switch to manual, then back to auto -> dwell restarts; 15 -> 0 wrap recaptures snap.

Source files
------------

// File: rtl/mem_led_scanner.sv
// Scans a coherent 16-byte memory snapshot onto 8 LEDs, one byte at a time, either
// auto-timed (fixed dwell) or stepped by a debounced pushbutton; outputs lag index/snapshot by 1 cycle.
module mem_led_scanner #(
  parameter int unsigned DWELL_CYCLES    = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] mem_bytes,
  input  logic         mode_auto,
  input  logic         btn_next,
  input  logic         hold,
  output logic [7:0]   led,
  output logic [3:0]   led_index,
  output logic         adv_pulse
);

  localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned BW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {S_LOAD, S_AUTO, S_MANUAL} state_t;

  state_t          state_q, state_d;
  logic [3:0]      index_q, index_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic [127:0]    snap_q, snap_d;
  logic            btn_meta_q, btn_sync_q;
  logic            deb_q, deb_d;
  logic [BW-1:0]   deb_cnt_q, deb_cnt_d;
  logic            rise_q;
  logic            step;
  logic            step_q;
  logic [7:0]      led_q;
  logic [3:0]      led_index_q;
  logic            adv_q;

  // Debounced level only follows the synced button after a full run of disagreeing samples.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (btn_sync_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d = btn_sync_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    dwell_d = dwell_q;
    snap_d  = snap_q;
    step    = 1'b0;
    if (!hold) begin
      case (state_q)
        S_LOAD: begin
          snap_d  = mem_bytes;
          dwell_d = '0;
          state_d = mode_auto ? S_AUTO : S_MANUAL;
        end
        S_AUTO: begin
          if (!mode_auto) begin
            state_d = S_MANUAL;
            dwell_d = '0;
          end else if (dwell_q == DWELL_LAST) begin
            dwell_d = '0;
            step    = 1'b1;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
        S_MANUAL: begin
          if (mode_auto) begin
            state_d = S_AUTO;
            dwell_d = '0;
          end else if (rise_q) begin
            step = 1'b1;
          end
        end
        default: state_d = S_LOAD;
      endcase
    end
    // A wrap starts a new sweep, so it takes a fresh copy of memory.
    if (step) begin
      index_d = index_q + 4'd1;
      if (index_q == 4'hF) begin
        snap_d = mem_bytes;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD;
      index_q     <= '0;
      dwell_q     <= '0;
      snap_q      <= '0;
      btn_meta_q  <= 1'b0;
      btn_sync_q  <= 1'b0;
      deb_q       <= 1'b0;
      deb_cnt_q   <= '0;
      rise_q      <= 1'b0;
      step_q      <= 1'b0;
      led_q       <= '0;
      led_index_q <= '0;
      adv_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      dwell_q     <= dwell_d;
      snap_q      <= snap_d;
      btn_meta_q  <= btn_next;
      btn_sync_q  <= btn_meta_q;
      deb_q       <= deb_d;
      deb_cnt_q   <= deb_cnt_d;
      rise_q      <= deb_d & ~deb_q;
      step_q      <= step;
      led_q       <= snap_q[{index_q, 3'b000} +: 8];
      led_index_q <= index_q;
      adv_q       <= step_q;
    end
  end

  assign led       = led_q;
  assign led_index = led_index_q;
  assign adv_pulse = adv_q;

endmodule

// File: tb/tb_mem_led_scanner.sv
// Directed scenarios plus a random phase, every cycle compared to a byte-array model of the scanner.
module tb_mem_led_scanner;

  localparam int DWELL = 4;
  localparam int DEB   = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] mem_bytes;
  logic         mode_auto, btn_next, hold;
  logic [7:0]   led;
  logic [3:0]   led_index;
  logic         adv_pulse;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;

  mem_led_scanner #(.DWELL_CYCLES(DWELL), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk(clk), .rst_n(rst_n), .mem_bytes(mem_bytes), .mode_auto(mode_auto),
    .btn_next(btn_next), .hold(hold), .led(led), .led_index(led_index), .adv_pulse(adv_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0=load, 1=auto, 2=manual; snapshot kept as a byte array.
  byte unsigned m_snap[16];
  int           m_mode, m_idx, m_dwell, m_run;
  bit           m_pipe[$];
  bit           m_deb, m_rise, m_advp;
  logic [7:0]   e_led;
  logic [3:0]   e_idx;
  logic         e_adv;

  task automatic model_reset();
    foreach (m_snap[i]) m_snap[i] = 8'h00;
    m_mode = 0; m_idx = 0; m_dwell = 0; m_run = 0;
    m_pipe = '{1'b0, 1'b0};
    m_deb = 0; m_rise = 0; m_advp = 0;
    e_led = 8'h00; e_idx = 4'h0; e_adv = 1'b0;
  endtask

  task automatic model_edge();
    bit synced, req, adv;
    e_idx  = 4'(m_idx);
    e_led  = m_snap[m_idx];
    e_adv  = m_advp;
    synced = m_pipe.pop_front();
    m_pipe.push_back(btn_next);
    req    = m_rise;
    m_rise = 0;
    if (synced != m_deb) begin
      m_run++;
      if (m_run == DEB) begin
        m_deb  = synced;
        m_run  = 0;
        m_rise = synced;
      end
    end else begin
      m_run = 0;
    end
    adv = 0;
    if (!hold) begin
      if (m_mode == 0) begin
        for (int i = 0; i < 16; i++) m_snap[i] = mem_bytes[8*i +: 8];
        m_mode = mode_auto ? 1 : 2;
        m_dwell = 0;
      end else if (m_mode == 1) begin
        if (!mode_auto) begin
          m_mode = 2; m_dwell = 0;
        end else if (m_dwell == DWELL - 1) begin
          m_dwell = 0; adv = 1;
        end else begin
          m_dwell++;
        end
      end else begin
        if (mode_auto) begin
          m_mode = 1; m_dwell = 0;
        end else if (req) begin
          adv = 1;
        end
      end
    end
    if (adv) begin
      if (m_idx == 15)
        for (int i = 0; i < 16; i++) m_snap[i] = mem_bytes[8*i +: 8];
      m_idx = (m_idx + 1) % 16;
    end
    m_advp = adv;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_led", led, e_led);
    chk("model_led_index", {4'h0, led_index}, {4'h0, e_idx});
    chk("model_adv_pulse", {7'h0, adv_pulse}, {7'h0, e_adv});
    if (adv_pulse) pulse_cnt++;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_idx(input logic [3:0] target, input int budget);
    bit found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      tick();
      found = adv_pulse && (led_index == target);
    end
    checks++;
    assert (found) else begin
      errors++;
      $error("FAIL wait_idx timeout observed=%0d expected=%0d", led_index, target);
    end
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 16; i++) mem_bytes[8*i +: 8] = 8'($urandom);
  endtask

  initial begin
    int gap, n, pulses;
    logic [7:0] byte0;
    rst_n = 1'b1; mode_auto = 1'b1; btn_next = 1'b0; hold = 1'b0;
    for (int i = 0; i < 16; i++) mem_bytes[8*i +: 8] = 8'(i + 1);
    model_reset();
    #1 rst_n = 1'b0;
    #11;
    chk("reset_led", led, 8'h00);
    chk("reset_led_index", {4'h0, led_index}, 8'h00);
    chk("reset_adv", {7'h0, adv_pulse}, 8'h00);
    @(negedge clk) rst_n = 1'b1;

    // 1. auto sweep
    tick_n(2);
    chk("first_led", led, 8'h01);
    gap = 0; pulses = 0;
    for (int c = 0; c < 200 && pulses < 16; c++) begin
      tick();
      gap++;
      if (adv_pulse) begin
        if (pulses > 0) chk("dwell_gap", 8'(gap), 8'(DWELL));
        pulses++;
        chk("sweep_index", {4'h0, led_index}, 8'(pulses % 16));
        chk("sweep_led", led, 8'(pulses % 16 + 1));
        gap = 0;
      end
    end
    chk("sweep_pulses", 8'(pulses), 8'd16);

    // 2. coherent snapshot
    wait_idx(4'd5, 40);
    mem_bytes = {16{8'hAA}};
    for (int k = 6; k <= 16; k++) begin
      wait_idx(4'(k % 16), 10);
      chk("coherent_led", led, (k == 16) ? 8'hAA : 8'(k + 1));
    end

    // 3. manual debounce
    mode_auto = 1'b0;
    tick_n(3);
    pulse_cnt = 0;
    btn_next = 1'b1; tick_n(1); btn_next = 1'b0; tick_n(5);
    btn_next = 1'b1; tick_n(2); btn_next = 1'b0; tick_n(8);
    chk("glitch_no_step", {4'h0, led_index}, 8'h00);
    btn_next = 1'b1; tick_n(10); btn_next = 1'b0; tick_n(10);
    chk("press1_index", {4'h0, led_index}, 8'h01);
    chk("press1_led", led, 8'hAA);
    chk("press1_pulses", 8'(pulse_cnt), 8'd1);
    btn_next = 1'b1; tick_n(10); btn_next = 1'b0; tick_n(10);
    chk("press2_index", {4'h0, led_index}, 8'h02);

    // random phase: bouncy button, hold, mode and memory changes
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(5) == 0) btn_next = ~btn_next;
      if ($urandom_range(24) == 0) hold = ~hold;
      if ($urandom_range(49) == 0) mode_auto = ~mode_auto;
      if ($urandom_range(39) == 0) rand_mem();
      tick();
    end

    // 4. hold at index 7 with dwell 2
    hold = 1'b0; btn_next = 1'b0; mode_auto = 1'b1;
    tick_n(10);
    wait_idx(4'd7, 100);
    tick();
    hold = 1'b1;
    for (int i = 0; i < 20; i++) begin
      btn_next  = (i >= 2 && i < 9);
      if (i == 5)  mode_auto = 1'b0;
      if (i == 12) mode_auto = 1'b1;
      tick();
      chk("hold_index", {4'h0, led_index}, 8'h07);
      chk("hold_no_pulse", {7'h0, adv_pulse}, 8'h00);
    end
    hold = 1'b0;
    n = 0;
    for (int i = 0; i < 10 && !adv_pulse; i++) begin tick(); n++; end
    // dwell 2->3, then the index steps; the outputs show it one cycle later
    chk("hold_resume_latency", 8'(n), 8'd3);
    chk("hold_resume_index", {4'h0, led_index}, 8'h08);

    // 5. async reset mid-sweep
    wait_idx(4'd9, 80);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_led", led, 8'h00);
    chk("async_rst_index", {4'h0, led_index}, 8'h00);
    chk("async_rst_adv", {7'h0, adv_pulse}, 8'h00);
    model_reset();
    rand_mem();
    byte0 = mem_bytes[7:0];
    @(negedge clk) rst_n = 1'b1;
    tick_n(2);
    chk("reload_led", led, byte0);

    // 6. button ignored in auto, manual round trip, wrap recapture
    wait_idx(4'd14, 80);
    btn_next = 1'b1;
    tick_n(6);
    mode_auto = 1'b0; btn_next = 1'b0;
    tick_n(4);
    chk("auto_btn_ignored", {4'h0, led_index}, 8'h0F);
    rand_mem();
    byte0 = mem_bytes[7:0];
    mode_auto = 1'b1;
    n = 0;
    for (int i = 0; i < 12 && !adv_pulse; i++) begin tick(); n++; end
    chk("dwell_restart", 8'(n), 8'd6);
    chk("wrap_index", {4'h0, led_index}, 8'h00);
    chk("wrap_led", led, byte0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
